// File: rtl/alu_shift_seq.sv
// Bit-serial SHL/SHR/SAR shifter with valid/ready request and response handshakes.
// Optional ROL/ROR support is enabled by defining ALU_SHIFT_ROTATE_EN.
module alu_shift_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       Opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       Flags,
  output logic             err
);
  localparam int SW = $clog2(WIDTH);

  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_SHR = 5'b01001;
  localparam logic [4:0] OP_SAR = 5'b01010;
`ifdef ALU_SHIFT_ROTATE_EN
  localparam logic [4:0] OP_ROL = 5'b01011;
  localparam logic [4:0] OP_ROR = 5'b01100;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [4:0]      op;
  logic [SW-1:0]   count;
  logic            c_q, v_q;
  logic            accept, req_sup, req_zero, last_step;
  logic [WIDTH-1:0] step_val;
  logic            step_c, step_v;
  logic            unused_b;

  function automatic logic supported(input logic [4:0] o);
`ifdef ALU_SHIFT_ROTATE_EN
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_SAR) || (o == OP_ROL) || (o == OP_ROR);
`else
    return (o == OP_SHL) || (o == OP_SHR) || (o == OP_SAR);
`endif
  endfunction

  assign unused_b  = ^B[WIDTH-1:SW];
  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign req_sup   = supported(Opcode);
  assign req_zero  = (B[SW-1:0] == '0);
  assign last_step = (count == SW'(1));

  // One-bit step on the working value; V only accumulates for SHL.
  always_comb begin
    step_val = Result;
    step_c   = c_q;
    step_v   = v_q;
    case (op)
      OP_SHL: begin
        step_val = {Result[WIDTH-2:0], 1'b0};
        step_c   = Result[WIDTH-1];
        step_v   = v_q | (Result[WIDTH-1] ^ Result[WIDTH-2]);
      end
      OP_SHR: begin
        step_val = {1'b0, Result[WIDTH-1:1]};
        step_c   = Result[0];
      end
      OP_SAR: begin
        step_val = {Result[WIDTH-1], Result[WIDTH-1:1]};
        step_c   = Result[0];
      end
`ifdef ALU_SHIFT_ROTATE_EN
      OP_ROL: begin
        step_val = {Result[WIDTH-2:0], Result[WIDTH-1]};
        step_c   = Result[WIDTH-1];
      end
      OP_ROR: begin
        step_val = {Result[0], Result[WIDTH-1:1]};
        step_c   = Result[0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (req_zero || !req_sup) ? DONE : SHIFT;
      SHIFT:   if (last_step) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Result <= '0;
      Flags  <= 4'b0000;
      err    <= 1'b0;
      count  <= '0;
      op     <= '0;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          Result <= A;
          op     <= Opcode;
          count  <= B[SW-1:0];
          c_q    <= 1'b0;
          v_q    <= 1'b0;
          err    <= !req_sup;
          // No shift will run: flags come straight from the operand.
          if (req_zero || !req_sup) Flags <= {2'b00, A[WIDTH-1], A == '0};
        end
        SHIFT: begin
          Result <= step_val;
          c_q    <= step_c;
          v_q    <= step_v;
          count  <= count - SW'(1);
          if (last_step) Flags <= {step_v, step_c, step_val[WIDTH-1], step_val == '0};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_shift_seq.sv
// Scoreboard bench for alu_shift_seq: driver pushes model results, monitor pops on out_valid.
module tb_alu_shift_seq;
  localparam logic [4:0] SHL = 5'b01000;
  localparam logic [4:0] SHR = 5'b01001;
  localparam logic [4:0] SAR = 5'b01010;
  localparam logic [4:0] ROL = 5'b01011;
  localparam logic [4:0] ROR = 5'b01100;

  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic        in_ready, out_valid, err;
  logic [31:0] A = 0, B = 0, Result;
  logic [4:0]  Opcode = 0;
  logic [3:0]  Flags;

  int total = 0, bad = 0, ncyc = 0;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flg;
    logic        e;
    int          cyc;
    int          hold;
  } exp_t;
  exp_t sbq[$];

  alu_shift_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Opcode(Opcode), .out_valid(out_valid), .out_ready(out_ready),
    .Result(Result), .Flags(Flags), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ncyc <= ncyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  // Reference: whole-shift arithmetic, carry/overflow read straight off the operand bits.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                                output logic [31:0] r, output logic [3:0] f, output logic e,
                                output int lat);
    int n;
    logic c, v, sup;
    longint top;
    n = int'(b[4:0]);
    c = 0; v = 0;
    sup = (op == SHL) || (op == SHR) || (op == SAR);
`ifdef ALU_SHIFT_ROTATE_EN
    sup = sup || (op == ROL) || (op == ROR);
`endif
    r = a; e = !sup; lat = 0;
    if (sup && n > 0) begin
      lat = n;
      case (op)
        SHL: begin
          r = a << n;
          c = a[32-n];
          top = longint'(a) >> (31 - n);
          v = !(top == 0 || top == ((longint'(1) << (n + 1)) - 1));
        end
        SHR: begin r = a >> n; c = a[n-1]; end
        SAR: begin r = $signed(a) >>> n; c = a[n-1]; end
        ROL: begin r = (a << n) | (a >> (32 - n)); c = r[0]; end
        ROR: begin r = (a >> n) | (a << (32 - n)); c = r[31]; end
        default: ;
      endcase
    end
    f = {v, c, r[31], r == 32'd0};
  endfunction

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op, input int hold);
    exp_t ex;
    int t, lat;
    @(negedge clk);
    in_valid = 1; A = a; B = b; Opcode = op;
    t = 0;
    while (!in_ready && t < 300) begin @(negedge clk); t++; end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL accept_timeout: in_ready got 0 want 1 (cycle %0d)", ncyc);
      in_valid = 0;
      return;
    end
    model(a, b, op, ex.res, ex.flg, ex.e, lat);
    ex.cyc  = ncyc + 1 + lat;
    ex.hold = hold;
    sbq.push_back(ex);
    @(posedge clk);
    #1;
    in_valid = 0; A = $urandom; B = $urandom; Opcode = 5'($urandom);
  endtask

  // Monitor: compares first DONE cycle, then stability while the consumer stalls.
  initial begin : mon
    logic prev, just_done;
    exp_t cur;
    int hold;
    prev = 0; just_done = 0; hold = 0;
    cur = '{res: 0, flg: 0, e: 0, cyc: 0, hold: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 0; just_done = 0; out_ready = 0;
      end else begin
        if (just_done) begin
          chk("valid_drop_after_take", out_valid, 0);
          chk("ready_after_take", in_ready, 1);
          just_done = 0;
        end
        if (out_valid) begin
          if (!prev) begin
            if (sbq.size() == 0) begin
              total++; bad++;
              $display("FAIL unexpected_out: got Result %0h want no output", Result);
              cur = '{res: Result, flg: Flags, e: err, cyc: ncyc, hold: 0};
              hold = 0;
            end else begin
              cur = sbq.pop_front();
              chk("result", Result, cur.res);
              chk("flags", Flags, cur.flg);
              chk("err", err, cur.e);
              chk("latency_cycle", ncyc, cur.cyc);
              hold = (cur.hold >= 0) ? cur.hold : int'($urandom_range(0, 3));
            end
            prev = 1;
          end else begin
            chk("result_stable", Result, cur.res);
            chk("flags_stable", Flags, cur.flg);
            chk("err_stable", err, cur.e);
          end
          chk("in_ready_busy", in_ready, 0);
          out_ready = (hold == 0);
          if (hold > 0) hold--;
          if (out_ready) begin prev = 0; just_done = 1; end
        end else begin
          prev = 0; out_ready = 0;
        end
      end
    end
  end

  initial begin : drv
    logic [4:0] ops [6];
    logic [31:0] b;
    int t;
    ops = '{SHL, SHR, SAR, ROL, ROR, 5'b00000};

    rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", Result, 0);
    chk("rst_flags", Flags, 0);
    chk("rst_err", err, 0);
    rst = 0;
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);

    send(32'd5, 32'd1, SHL, 0);
    send(32'h8000_0000, 32'd1, SHL, -1);
    send(32'h8000_0000, 32'd1, SHR, -1);
    send(32'hFFFF_FFF8, 32'd1, SAR, 0);
    send(32'hFFFF_FFF8, 32'd31, SAR, -1);
    send(32'h1234_5678, 32'd0, SHR, 0);
    send(32'hC000_0001, 32'd3, SHL, 5);
    send(32'h8000_0001, 32'd4, ROL, -1);
    send(32'h8000_0001, 32'd4, ROR, -1);
    send(32'hDEAD_BEEF, 32'd7, 5'b11111, -1);
    send(32'h0000_00F0, 32'hFFFF_FFE3, SHR, 0);

    // Reset in the middle of a long shift discards the operation.
    send(32'hA5A5_A5A5, 32'd20, SHL, 0);
    repeat (8) @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_result", Result, 0);
    chk("midrst_flags", Flags, 0);
    chk("midrst_in_ready", in_ready, 0);
    sbq.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    send(32'h0000_0003, 32'd2, SHL, 0);

    for (int i = 0; i < 60; i++) begin
      b = $urandom;
      if ($urandom_range(0, 1) == 0) b[4:0] = 5'($urandom_range(0, 3));
      send($urandom, b, ops[$urandom_range(0, 5)], -1);
    end

    t = 0;
    while ((sbq.size() != 0 || out_valid) && t < 2000) begin @(negedge clk); t++; end
    if (t >= 2000) begin
      total++; bad++;
      $display("FAIL drain_timeout: pending %0d want 0", sbq.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
